// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory client of dmem_arbiter (core or DMA).
// The x_fault return wire exists only when DMEM_ARB_FAULT_EN is defined.
interface dmem_arbiter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req;
   logic                  we;
   logic                  lock;
   logic [DM_ADDRESS-1:0] addr;
   logic [DATA_W-1:0]     wd;
   logic [2:0]            funct3;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rd;
`ifdef DMEM_ARB_FAULT_EN
   logic                  fault;

   modport master (output req, we, lock, addr, wd, funct3,
                   input  gnt, rvalid, rd, fault);
   modport slave  (input  req, we, lock, addr, wd, funct3,
                   output gnt, rvalid, rd, fault);
`else
   modport master (output req, we, lock, addr, wd, funct3,
                   input  gnt, rvalid, rd);
   modport slave  (input  req, we, lock, addr, wd, funct3,
                   output gnt, rvalid, rd);
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between core (c) and DMA (d), with capped lock bursts.
// Optional DMEM_ARB_FAULT_EN: misaligned accesses are granted but suppressed and reported via x_fault.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   dmem_arbiter_if.slave         c,
   dmem_arbiter_if.slave         d,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   output logic [2:0]            Funct3,
   input  logic [DATA_W-1:0]     rd
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

   state_t             state_q, state_d;
   logic               prioD_q, prioD_d;
   logic [CNT_W-1:0]   burstCnt_q, burstCnt_d;
   logic [CNT_W-1:0]   burstInc;
   logic               cGnt, dGnt;
   logic               cMis, dMis;
   logic               cRvalid_q, dRvalid_q;
   logic [DATA_W-1:0]  cRd_q, dRd_q;
   logic               cFault_q, dFault_q;

`ifdef DMEM_ARB_FAULT_EN
   function automatic logic misaligned(input logic [2:0] f, input logic [1:0] lo);
      logic half, word;
      half = (f[1:0] == 2'b01) && lo[0];
      word = (f == 3'b010) && (lo != 2'b00);
      return half || word;
   endfunction

   assign cMis    = misaligned(c.funct3, c.addr[1:0]);
   assign dMis    = misaligned(d.funct3, d.addr[1:0]);
   assign c.fault = cFault_q;
   assign d.fault = dFault_q;
`else
   assign cMis = 1'b0;
   assign dMis = 1'b0;
`endif

   assign burstInc = burstCnt_q + CNT_W'(1);

   // Grant selection and ownership tracking; the lock owner is only released on drop or cap.
   always_comb begin
      cGnt       = 1'b0;
      dGnt       = 1'b0;
      state_d    = state_q;
      prioD_d    = prioD_q;
      burstCnt_d = burstCnt_q;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (c.req && (!d.req || !prioD_q)) begin
                  cGnt    = 1'b1;
                  prioD_d = 1'b1;
                  if (c.lock) begin
                     state_d    = OWN_C;
                     burstCnt_d = CNT_W'(1);
                  end
               end else if (d.req) begin
                  dGnt    = 1'b1;
                  prioD_d = 1'b0;
                  if (d.lock) begin
                     state_d    = OWN_D;
                     burstCnt_d = CNT_W'(1);
                  end
               end
            end
            OWN_C: begin
               if (c.req && c.lock) begin
                  cGnt       = 1'b1;
                  burstCnt_d = burstInc;
               end
               if (!(c.req && c.lock) || burstInc == CNT_W'(MAX_BURST)) begin
                  state_d    = IDLE;
                  prioD_d    = 1'b1;
                  burstCnt_d = '0;
               end
            end
            OWN_D: begin
               if (d.req && d.lock) begin
                  dGnt       = 1'b1;
                  burstCnt_d = burstInc;
               end
               if (!(d.req && d.lock) || burstInc == CNT_W'(MAX_BURST)) begin
                  state_d    = IDLE;
                  prioD_d    = 1'b0;
                  burstCnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Memory-side mux: everything zero when nobody is granted, strobes also masked by a fault.
   always_comb begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      a        = '0;
      wd       = '0;
      Funct3   = '0;
      if (cGnt) begin
         MemRead  = !c.we && !cMis;
         MemWrite = c.we && !cMis;
         a        = c.addr;
         wd       = c.wd;
         Funct3   = c.funct3;
      end else if (dGnt) begin
         MemRead  = !d.we && !dMis;
         MemWrite = d.we && !dMis;
         a        = d.addr;
         wd       = d.wd;
         Funct3   = d.funct3;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         prioD_q    <= 1'b0;
         burstCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         prioD_q    <= prioD_d;
         burstCnt_q <= burstCnt_d;
      end
   end

   // Read data returns one cycle after the grant; rd is held between reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cRvalid_q <= 1'b0;
         dRvalid_q <= 1'b0;
         cRd_q     <= '0;
         dRd_q     <= '0;
         cFault_q  <= 1'b0;
         dFault_q  <= 1'b0;
      end else begin
         cRvalid_q <= cGnt && !c.we && !cMis;
         dRvalid_q <= dGnt && !d.we && !dMis;
         cFault_q  <= cGnt && cMis;
         dFault_q  <= dGnt && dMis;
         if (cGnt && !c.we && !cMis) cRd_q <= rd;
         if (dGnt && !d.we && !dMis) dRd_q <= rd;
      end
   end

   assign c.gnt    = cGnt;
   assign d.gnt    = dGnt;
   assign c.rvalid = cRvalid_q;
   assign d.rvalid = dRvalid_q;
   assign c.rd     = cRd_q;
   assign d.rd     = dRd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed testbench for dmem_arbiter against a cycle-level reference model.
// Define DMEM_ARB_FAULT_EN to also exercise misaligned-access fault reporting.
module tb_dmem_arbiter;

   localparam int DM_ADDRESS = 9;
   localparam int DATA_W     = 32;
   localparam int MAX_BURST  = 8;

   logic              clk;
   logic              reset;
   logic              memInit;
   logic              MemRead, MemWrite;
   logic [8:0]        memA;
   logic [31:0]       memWd;
   logic [2:0]        memF3;
   logic [31:0]       memRd;
   logic [31:0]       memArray [0:127];
   logic [31:0]       modelMem [0:127];

   int vectors     = 0;
   int miscompares = 0;

   // model state: owner 0=none 1=C 2=D, turn 0=C first 1=D first
   int   owner, streak, turn;
   bit   pendCValid, pendDValid, pendCFault, pendDFault;
   logic [31:0] pendCData, pendDData;
   logic lastCGnt, lastDGnt;

   dmem_arbiter_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) cIf ();
   dmem_arbiter_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dIf ();

   dmem_arbiter #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk      (clk),
      .reset    (reset),
      .c        (cIf),
      .d        (dIf),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .a        (memA),
      .wd       (memWd),
      .Funct3   (memF3),
      .rd       (memRd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple word-wide memory standing in for the real data memory.
   assign memRd = memArray[memA[8:2]];
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 128; i++) memArray[i] <= 32'h1357_9BDF ^ (i * 32'h0101_0101);
      end else if (MemWrite) begin
         memArray[memA[8:2]] <= memWd;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

`ifdef DMEM_ARB_FAULT_EN
   function automatic bit tbMis(input logic [2:0] f, input logic [8:0] ad);
      if ((f == 3'b001 || f == 3'b101) && ad[0]) return 1'b1;
      if (f == 3'b010 && ad[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction
`endif

   task automatic modelReset();
      owner = 0; streak = 0; turn = 0;
      pendCValid = 0; pendDValid = 0; pendCFault = 0; pendDFault = 0;
      pendCData = '0; pendDData = '0;
   endtask

   // Drive one cycle of requests (called at negedge), check everything, advance the model.
   task automatic applyStimulus(
      input logic cReq, input logic cWe, input logic cLock, input logic [8:0] cAddr,
      input logic [31:0] cWd, input logic [2:0] cF,
      input logic dReq, input logic dWe, input logic dLock, input logic [8:0] dAddr,
      input logic [31:0] dWd, input logic [2:0] dF);
      bit gc, gd, cMisE, dMisE, expRd, expWr;
      logic [8:0]  expA;
      logic [31:0] expWd;
      logic [2:0]  expF;
      cIf.req = cReq; cIf.we = cWe; cIf.lock = cLock; cIf.addr = cAddr; cIf.wd = cWd; cIf.funct3 = cF;
      dIf.req = dReq; dIf.we = dWe; dIf.lock = dLock; dIf.addr = dAddr; dIf.wd = dWd; dIf.funct3 = dF;
      #1;
      checkOutput("cRvalid", cIf.rvalid, pendCValid);
      checkOutput("dRvalid", dIf.rvalid, pendDValid);
      if (pendCValid) checkOutput("cRd", cIf.rd, pendCData);
      if (pendDValid) checkOutput("dRd", dIf.rd, pendDData);
`ifdef DMEM_ARB_FAULT_EN
      checkOutput("cFault", cIf.fault, pendCFault);
      checkOutput("dFault", dIf.fault, pendDFault);
      cMisE = tbMis(cF, cAddr);
      dMisE = tbMis(dF, dAddr);
`else
      cMisE = 0;
      dMisE = 0;
`endif
      gc = 0; gd = 0;
      if (owner == 1)      gc = cReq && cLock;
      else if (owner == 2) gd = dReq && dLock;
      else if (cReq && (!dReq || turn == 0)) gc = 1;
      else if (dReq) gd = 1;
      expRd = (gc && !cWe && !cMisE) || (gd && !dWe && !dMisE);
      expWr = (gc && cWe && !cMisE) || (gd && dWe && !dMisE);
      expA  = gc ? cAddr : (gd ? dAddr : 9'd0);
      expWd = gc ? cWd : (gd ? dWd : 32'd0);
      expF  = gc ? cF : (gd ? dF : 3'd0);
      checkOutput("cGnt", cIf.gnt, gc);
      checkOutput("dGnt", dIf.gnt, gd);
      checkOutput("MemRead", MemRead, expRd);
      checkOutput("MemWrite", MemWrite, expWr);
      checkOutput("addr", memA, expA);
      checkOutput("wdata", memWd, expWd);
      checkOutput("funct3", memF3, expF);
      lastCGnt = cIf.gnt;
      lastDGnt = dIf.gnt;
      @(posedge clk);
      pendCValid = gc && !cWe && !cMisE;
      pendDValid = gd && !dWe && !dMisE;
      pendCFault = gc && cMisE;
      pendDFault = gd && dMisE;
      if (pendCValid) pendCData = modelMem[cAddr[8:2]];
      if (pendDValid) pendDData = modelMem[dAddr[8:2]];
      if (gc && cWe && !cMisE) modelMem[cAddr[8:2]] = cWd;
      if (gd && dWe && !dMisE) modelMem[dAddr[8:2]] = dWd;
      if (owner == 0) begin
         if (gc) begin turn = 1; if (cLock) begin owner = 1; streak = 1; end end
         if (gd) begin turn = 0; if (dLock) begin owner = 2; streak = 1; end end
      end else begin
         if (gc || gd) streak++;
         if (!(gc || gd) || streak == MAX_BURST) begin
            turn   = (owner == 1) ? 1 : 0;
            owner  = 0;
            streak = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idleStep();
      applyStimulus(0, 0, 0, 9'd0, 32'd0, 3'd0, 0, 0, 0, 9'd0, 32'd0, 3'd0);
   endtask

   // Reset asserted mid-cycle while the previous requests are still applied.
   task automatic resetMidCycle();
      #2 reset = 1'b1;
      #1;
      checkOutput("rstCGnt", cIf.gnt, 1'b0);
      checkOutput("rstDGnt", dIf.gnt, 1'b0);
      checkOutput("rstMemRead", MemRead, 1'b0);
      checkOutput("rstMemWrite", MemWrite, 1'b0);
      checkOutput("rstCRvalid", cIf.rvalid, 1'b0);
      checkOutput("rstDRvalid", dIf.rvalid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      modelReset();
   endtask

   initial begin
      logic [2:0] f3Table [0:4];
      int dCount;
      f3Table[0] = 3'b000; f3Table[1] = 3'b001; f3Table[2] = 3'b010;
      f3Table[3] = 3'b100; f3Table[4] = 3'b101;
      reset   = 1'b1;
      memInit = 1'b1;
      cIf.req = 0; cIf.we = 0; cIf.lock = 0; cIf.addr = '0; cIf.wd = '0; cIf.funct3 = '0;
      dIf.req = 0; dIf.we = 0; dIf.lock = 0; dIf.addr = '0; dIf.wd = '0; dIf.funct3 = '0;
      for (int i = 0; i < 128; i++) modelMem[i] = 32'h1357_9BDF ^ (i * 32'h0101_0101);
      modelReset();
      lastCGnt = 0; lastDGnt = 0;
      @(posedge clk);
      @(negedge clk);
      memInit = 1'b0;
      checkOutput("initCRvalid", cIf.rvalid, 1'b0);
      checkOutput("initCRd", cIf.rd, 32'd0);
      checkOutput("initDRd", dIf.rd, 32'd0);
      reset = 1'b0;

      // simultaneous loads after reset: C first, then alternation
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 0, 0, 9'(4 * i), 32'd0, 3'b010, 1, 0, 0, 9'(64 + 4 * i), 32'd0, 3'b010);
      idleStep();

      // D stores, then C loads the same word
      applyStimulus(0, 0, 0, 9'd0, 32'd0, 3'd0, 1, 1, 0, 9'h010, 32'hDEAD_BEEF, 3'b010);
      applyStimulus(1, 0, 0, 9'h010, 32'd0, 3'b010, 0, 0, 0, 9'd0, 32'd0, 3'd0);
      idleStep();
      checkOutput("wrRdData", cIf.rd, 32'hDEAD_BEEF);

      // reset with a read in flight, then C must win a tie
      applyStimulus(1, 0, 0, 9'h020, 32'd0, 3'b010, 1, 0, 0, 9'h024, 32'd0, 3'b010);
      resetMidCycle();
      applyStimulus(1, 0, 0, 9'h020, 32'd0, 3'b010, 1, 0, 0, 9'h024, 32'd0, 3'b010);
      checkOutput("tieAfterReset", lastCGnt, 1'b1);

      // D locked burst capped at MAX_BURST despite C waiting
      resetMidCycle();
      dCount = 0;
      applyStimulus(0, 0, 0, 9'd0, 32'd0, 3'd0, 1, 0, 1, 9'h040, 32'd0, 3'b010);
      dCount += int'(lastDGnt);
      for (int i = 1; i < 12; i++) begin
         applyStimulus(1, 0, 0, 9'h008, 32'd0, 3'b010, 1, 0, 1, 9'(9'h040 + 4 * i), 32'd0, 3'b010);
         if (i < MAX_BURST) dCount += int'(lastDGnt);
         if (i == MAX_BURST) checkOutput("capCGnt", lastCGnt, 1'b1);
         if (i == MAX_BURST + 1) checkOutput("capDResume", lastDGnt, 1'b1);
      end
      checkOutput("capDCount", 32'(dCount), 32'(MAX_BURST));

      // C locks for 3 grants, drops lock: one dead cycle, then D
      resetMidCycle();
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 1, 9'(4 * i), 32'd0, 3'b010, 0, 0, 0, 9'd0, 32'd0, 3'd0);
      applyStimulus(1, 0, 0, 9'h00C, 32'd0, 3'b010, 1, 0, 0, 9'h030, 32'd0, 3'b010);
      checkOutput("relNoGnt", {31'd0, lastCGnt | lastDGnt}, 32'd0);
      applyStimulus(1, 0, 0, 9'h00C, 32'd0, 3'b010, 1, 0, 0, 9'h030, 32'd0, 3'b010);
      checkOutput("relDGnt", lastDGnt, 1'b1);
      idleStep();

`ifdef DMEM_ARB_FAULT_EN
      applyStimulus(1, 0, 0, 9'h013, 32'd0, 3'b010, 0, 0, 0, 9'd0, 32'd0, 3'd0);
      checkOutput("faultGnt", lastCGnt, 1'b1);
      idleStep();
`endif

      // randomized traffic with occasional mid-run resets
      for (int i = 0; i < 600; i++) begin
         logic [2:0] cf, df;
         cf = f3Table[$urandom_range(0, 4)];
         df = f3Table[$urandom_range(0, 4)];
         if (i == 200 || i == 450) resetMidCycle();
         applyStimulus(($urandom % 4) != 0, $urandom_range(0, 1) == 1, ($urandom % 3) == 0,
                       9'($urandom_range(0, 63)), $urandom, cf,
                       ($urandom % 4) != 0, $urandom_range(0, 1) == 1, ($urandom % 3) == 0,
                       9'($urandom_range(0, 63)), $urandom, df);
      end
      idleStep();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
